// File: rtl/jt49_div_multi.sv
// Multi-channel programmable clock-enable divider: each channel divides cen by
// its own W-bit period and produces a one-clk enable pulse plus a square wave.
module jt49_div_multi #(
  parameter int W  = 12,
  parameter int CH = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic [CH-1:0]   en,
  input  logic [CH-1:0]   restart,
  input  logic [CH*W-1:0] period,
  output logic [CH-1:0]   cen_div,
  output logic [CH-1:0]   sq
);

  localparam logic [W-1:0] ONE = W'(1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] cnt, cnt_nxt;
    logic [W-1:0] shadow, shadow_nxt;
    logic [W-1:0] lim;
    logic         sq_r, sq_nxt;
    logic         pulse_r, pulse_nxt;
    logic         en_q;
    logic         run, rise, term;

    always_comb begin
      // shadow of 0 behaves as a divisor of 1, so the terminal count is 0
      lim        = (shadow == '0) ? '0 : shadow - ONE;
      run        = cen & en[i];
      rise       = en[i] & ~en_q;
      term       = run & (cnt >= lim);
      cnt_nxt    = cnt;
      shadow_nxt = shadow;
      sq_nxt     = sq_r;
      pulse_nxt  = 1'b0;
      if (restart[i]) begin
        cnt_nxt    = '0;
        shadow_nxt = period[i*W +: W];
        sq_nxt     = 1'b0;
      end else if (rise) begin
        cnt_nxt    = '0;
        shadow_nxt = period[i*W +: W];
      end else if (term) begin
        cnt_nxt    = '0;
        shadow_nxt = period[i*W +: W];
        sq_nxt     = ~sq_r;
        pulse_nxt  = 1'b1;
      end else if (run) begin
        cnt_nxt    = cnt + ONE;
      end
    end

    // en_q resets high so a channel already enabled at reset release runs
    // with D = 1 until its first terminal, instead of seeing a false rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt     <= '0;
        shadow  <= '0;
        sq_r    <= 1'b0;
        pulse_r <= 1'b0;
        en_q    <= 1'b1;
      end else begin
        cnt     <= cnt_nxt;
        shadow  <= shadow_nxt;
        sq_r    <= sq_nxt;
        pulse_r <= pulse_nxt;
        en_q    <= en[i];
      end
    end

    assign cen_div[i] = pulse_r;
    assign sq[i]      = sq_r;
  end

endmodule

// File: tb/tb_jt49_div_multi.sv
// Scoreboard bench for jt49_div_multi: stimulus pushes hand-derived expected
// outputs per clk; a monitor pops and compares them at the falling edge.
module tb_jt49_div_multi;
  localparam int W  = 4;
  localparam int CH = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cen = 1'b0;
  logic [CH-1:0]   en = '0;
  logic [CH-1:0]   restart = '0;
  logic [CH*W-1:0] period = '0;
  logic [CH-1:0]   cen_div;
  logic [CH-1:0]   sq;

  jt49_div_multi #(.W(W), .CH(CH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .en      (en),
    .restart (restart),
    .period  (period),
    .cen_div (cen_div),
    .sq      (sq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] cd;
    logic [CH-1:0] sq;
    logic [CH-1:0] mcd;
    logic [CH-1:0] msq;
    string         tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  event ev_sample;

  initial begin
    forever begin
      @(negedge clk or ev_sample);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.mcd != '0) begin
          checks++;
          if (((cen_div ^ e.cd) & e.mcd) != '0) begin
            errors++;
            $display("FAIL %s cen_div: got %b expected %b (mask %b) t=%0t",
                     e.tag, cen_div, e.cd, e.mcd, $time);
          end
        end
        if (e.msq != '0) begin
          checks++;
          if (((sq ^ e.sq) & e.msq) != '0) begin
            errors++;
            $display("FAIL %s sq: got %b expected %b (mask %b) t=%0t",
                     e.tag, sq, e.sq, e.msq, $time);
          end
        end
      end
    end
  end

  task automatic push(input logic [CH-1:0] cd, s, mcd, msq, input string tag);
    exp_t x;
    x.cd = cd; x.sq = s; x.mcd = mcd; x.msq = msq; x.tag = tag;
    q.push_back(x);
  endtask

  // inputs set before the call are sampled at this edge; expectation is post-edge
  task automatic step(input logic [CH-1:0] cd, s, mcd, msq, input string tag);
    @(posedge clk);
    #1;
    push(cd, s, mcd, msq, tag);
  endtask

  task automatic run(input int n, input logic [CH-1:0] cd, s, mcd, msq,
                     input string tag);
    for (int k = 0; k < n; k++) step(cd, s, mcd, msq, tag);
  endtask

  task automatic set_period(input int ch, input int val);
    period[ch*W +: W] = val[W-1:0];
  endtask

  localparam logic [CH-1:0] ALL = '1;
  localparam logic [CH-1:0] C0  = 3'b001;
  localparam logic [CH-1:0] Z   = '0;

  initial begin
    logic [CH-1:0] cd, s;

    // reset state
    run(2, Z, Z, ALL, ALL, "reset");
    rst_n = 1'b1;

    // 1: periods 4/2/0 after restart
    set_period(0, 4); set_period(1, 2); set_period(2, 0);
    en = '1; cen = 1'b1; restart = '1;
    step(Z, Z, ALL, ALL, "t1_restart");
    restart = '0;
    for (int k = 1; k <= 16; k++) begin
      cd = {1'b1, (k % 2) == 0, (k % 4) == 0};
      s  = {(k % 2) == 1, ((k / 2) % 2) == 1, ((k / 4) % 2) == 1};
      step(cd, s, ALL, ALL, "t1_div");
    end

    // 2: period 5 -> 2 written at cnt 2; old period completes first
    set_period(0, 5); en = C0; restart = C0;
    step(Z, Z, ALL, C0, "t2_restart");
    restart = '0;
    run(2, Z, Z, ALL, C0, "t2_count");
    set_period(0, 2);
    run(2, Z, Z, ALL, C0, "t2_old_period");
    step(C0, C0, ALL, C0, "t2_old_term");
    step(Z,  C0, ALL, C0, "t2_new1");
    step(C0, Z,  ALL, C0, "t2_new_term1");
    step(Z,  Z,  ALL, C0, "t2_new2");
    step(C0, C0, ALL, C0, "t2_new_term2");

    // 3: cen every other clk, period 3; restart acts with cen low
    set_period(0, 3); cen = 1'b0; restart = C0;
    step(Z, Z, ALL, C0, "t3_restart_cen_low");
    restart = '0;
    for (int k = 1; k <= 12; k++) begin
      cen = ((k % 2) == 0);
      cd  = {2'b00, (k == 6) || (k == 12)};
      s   = {2'b00, (k >= 6) && (k < 12)};
      step(cd, s, ALL, C0, "t3_cen_half");
    end
    cen = 1'b1;

    // 4: period 6, restart at cnt 4, then restart coinciding with term
    set_period(0, 6); restart = C0;
    step(Z, Z, ALL, C0, "t4_restart");
    restart = '0;
    run(5, Z, Z, ALL, C0, "t4_count");
    step(C0, C0, ALL, C0, "t4_term");
    run(4, Z, C0, ALL, C0, "t4_count_hi");
    restart = C0;
    step(Z, Z, ALL, C0, "t4_restart_mid");
    restart = '0;
    run(5, Z, Z, ALL, C0, "t4_after_restart");
    step(C0, C0, ALL, C0, "t4_term_after_restart");
    run(5, Z, C0, ALL, C0, "t4_count_hi2");
    restart = C0;
    step(Z, Z, ALL, C0, "t4_restart_on_term");
    restart = '0;
    run(5, Z, Z, ALL, C0, "t4_count3");
    step(C0, C0, ALL, C0, "t4_term3");

    // 5: en[1] low for 10 clk mid-count, others unaffected
    set_period(0, 4); set_period(1, 3); set_period(2, 0);
    en = '1; restart = '1;
    step(Z, Z, ALL, ALL, "t5_restart");
    restart = '0;
    for (int k = 1; k <= 18; k++) begin
      en = {1'b1, !((k >= 5) && (k <= 14)), 1'b1};
      cd = {1'b1, (k == 3) || (k == 18), (k % 4) == 0};
      s  = {(k % 2) == 1, (k >= 3) && (k < 18), ((k / 4) % 2) == 1};
      step(cd, s, ALL, ALL, "t5_gate");
    end

    // 6: async reset while sq high, then D = 1 until the first terminal
    set_period(0, 4); set_period(1, 4); set_period(2, 4);
    en = '1; restart = '1;
    step(Z, Z, ALL, ALL, "t6_restart");
    restart = '0;
    run(3, Z, Z, ALL, ALL, "t6_count");
    step(ALL, ALL, ALL, ALL, "t6_sq_high");
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    push(Z, Z, ALL, ALL, "t6_async_clear");
    -> ev_sample;
    #1 rst_n = 1'b1;
    step(ALL, ALL, ALL, ALL, "t6_first_d1");
    run(3, Z, ALL, ALL, ALL, "t6_count_hi");
    step(ALL, Z, ALL, ALL, "t6_term");
    run(3, Z, Z, ALL, ALL, "t6_count_lo");
    step(ALL, ALL, ALL, ALL, "t6_term2");

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
